// File: rtl/mem_xbar_rr.sv
// Request/grant memory crossbar: NB_MST masters to NB_SLV address-mapped slaves plus an
// internal error slave, with per-slave round-robin arbitration and in-order response routing.
module mem_xbar_rr #(
  parameter int NB_MST      = 3,
  parameter int NB_SLV      = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 2,
  parameter logic [NB_SLV*ADDR_WIDTH-1:0] START_ADDR = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLV*ADDR_WIDTH-1:0] END_ADDR   = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF},
  parameter logic [DATA_WIDTH-1:0]        ERR_RDATA  = 32'hBADACCE5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NB_MST-1:0]              mst_req_i,
  input  logic [NB_MST*ADDR_WIDTH-1:0]   mst_addr_i,
  input  logic [NB_MST-1:0]              mst_we_i,
  input  logic [NB_MST*DATA_WIDTH/8-1:0] mst_be_i,
  input  logic [NB_MST*DATA_WIDTH-1:0]   mst_wdata_i,
  output logic [NB_MST-1:0]              mst_gnt_o,
  output logic [NB_MST-1:0]              mst_rvalid_o,
  output logic [NB_MST*DATA_WIDTH-1:0]   mst_rdata_o,
  output logic [NB_MST-1:0]              mst_err_o,
  output logic [NB_SLV-1:0]              slv_req_o,
  output logic [NB_SLV*ADDR_WIDTH-1:0]   slv_addr_o,
  output logic [NB_SLV-1:0]              slv_we_o,
  output logic [NB_SLV*DATA_WIDTH/8-1:0] slv_be_o,
  output logic [NB_SLV*DATA_WIDTH-1:0]   slv_wdata_o,
  input  logic [NB_SLV-1:0]              slv_gnt_i,
  input  logic [NB_SLV-1:0]              slv_rvalid_i,
  input  logic [NB_SLV*DATA_WIDTH-1:0]   slv_rdata_i,
  input  logic [NB_SLV-1:0]              slv_err_i
);

  localparam int BW   = DATA_WIDTH / 8;
  localparam int MW   = (NB_MST > 1) ? $clog2(NB_MST) : 1;
  localparam int TW   = $clog2(NB_SLV + 1);
  localparam int CNTW = $clog2(NB_SLV * OUTSTANDING + 2);
  localparam int PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int FW   = $clog2(OUTSTANDING + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(NB_SLV);

  logic [TW-1:0]   dec_tgt [NB_MST];
  logic [NB_MST-1:0] elig;
  logic [NB_MST-1:0] err_gnt;
  logic [NB_MST-1:0] gnt;
  logic [NB_SLV-1:0] win_vld;
  logic [MW-1:0]   win_idx [NB_SLV];
  logic [NB_SLV-1:0] slv_req;
  logic [NB_SLV-1:0] push;
  logic [NB_SLV-1:0] pop;
  logic [MW-1:0]   head [NB_SLV];

  logic [CNTW-1:0] cnt_q [NB_MST];
  logic [CNTW-1:0] cnt_d [NB_MST];
  logic [TW-1:0]   tgt_q [NB_MST];
  logic [TW-1:0]   tgt_d [NB_MST];
  logic [NB_MST-1:0] err_pend_q;
  logic [NB_MST-1:0] err_pend_d;
  logic [MW-1:0]   rr_q [NB_SLV];
  logic [MW-1:0]   rr_d [NB_SLV];
  logic [MW-1:0]   mem_q [NB_SLV][OUTSTANDING];
  logic [MW-1:0]   mem_d [NB_SLV][OUTSTANDING];
  logic [PW-1:0]   wr_q [NB_SLV];
  logic [PW-1:0]   wr_d [NB_SLV];
  logic [PW-1:0]   rd_q [NB_SLV];
  logic [PW-1:0]   rd_d [NB_SLV];
  logic [FW-1:0]   fcnt_q [NB_SLV];
  logic [FW-1:0]   fcnt_d [NB_SLV];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Decode (lowest matching slave wins) and target-lock filtering.
  always_comb begin
    for (int m = 0; m < NB_MST; m++) begin
      dec_tgt[m] = ERR_IDX;
      for (int s = NB_SLV - 1; s >= 0; s--) begin
        if (mst_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH] &&
            mst_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH])
          dec_tgt[m] = TW'(s);
      end
      elig[m]    = mst_req_i[m] && !((cnt_q[m] != '0) && (tgt_q[m] != dec_tgt[m]));
      err_gnt[m] = elig[m] && (dec_tgt[m] == ERR_IDX) && !rst;
    end
  end

  always_comb begin
    for (int s = 0; s < NB_SLV; s++) begin
      logic found;
      int   c;
      found      = 1'b0;
      win_idx[s] = '0;
      for (int k = 0; k < NB_MST; k++) begin
        c = int'(rr_q[s]) + k;
        if (c >= NB_MST) c = c - NB_MST;
        if (!found && elig[c] && (dec_tgt[c] == TW'(s))) begin
          found      = 1'b1;
          win_idx[s] = MW'(c);
        end
      end
      win_vld[s] = found;
      // A full ID FIFO masks the request even if a pop lands this cycle (no rvalid->req path).
      slv_req[s] = found && (fcnt_q[s] != FW'(OUTSTANDING)) && !rst;
      push[s]    = slv_req[s] && slv_gnt_i[s];
      pop[s]     = slv_rvalid_i[s] && (fcnt_q[s] != '0);
      head[s]    = mem_q[s][rd_q[s]];
    end
  end

  always_comb begin
    gnt = err_gnt;
    for (int s = 0; s < NB_SLV; s++) begin
      if (push[s]) gnt[win_idx[s]] = 1'b1;
    end
  end

  assign mst_gnt_o = gnt;
  assign slv_req_o = slv_req;

  always_comb begin
    slv_addr_o  = '0;
    slv_we_o    = '0;
    slv_be_o    = '0;
    slv_wdata_o = '0;
    for (int s = 0; s < NB_SLV; s++) begin
      if (slv_req[s]) begin
        slv_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH]  = mst_addr_i[int'(win_idx[s])*ADDR_WIDTH +: ADDR_WIDTH];
        slv_we_o[s]                             = mst_we_i[win_idx[s]];
        slv_be_o[s*BW +: BW]                    = mst_be_i[int'(win_idx[s])*BW +: BW];
        slv_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = mst_wdata_i[int'(win_idx[s])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The target lock makes error-slave and real-slave responses mutually exclusive per master.
  always_comb begin
    mst_rvalid_o = '0;
    mst_err_o    = '0;
    mst_rdata_o  = '0;
    for (int m = 0; m < NB_MST; m++) begin
      if (err_pend_q[m]) begin
        mst_rvalid_o[m]                         = 1'b1;
        mst_err_o[m]                            = 1'b1;
        mst_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = ERR_RDATA;
      end
      for (int s = 0; s < NB_SLV; s++) begin
        if (pop[s] && (head[s] == MW'(m))) begin
          mst_rvalid_o[m]                         = 1'b1;
          mst_err_o[m]                            = slv_err_i[s];
          mst_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = slv_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    err_pend_d = err_gnt;
    rr_d       = rr_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    fcnt_d     = fcnt_q;
    for (int m = 0; m < NB_MST; m++) begin
      if (gnt[m]) tgt_d[m] = dec_tgt[m];
      case ({gnt[m], mst_rvalid_o[m]})
        2'b10:   cnt_d[m] = cnt_q[m] + CNTW'(1);
        2'b01:   cnt_d[m] = cnt_q[m] - CNTW'(1);
        default: cnt_d[m] = cnt_q[m];
      endcase
    end
    for (int s = 0; s < NB_SLV; s++) begin
      if (push[s]) begin
        mem_d[s][wr_q[s]] = win_idx[s];
        wr_d[s]           = ptr_inc(wr_q[s]);
        rr_d[s]           = (win_idx[s] == MW'(NB_MST - 1)) ? '0 : win_idx[s] + MW'(1);
      end
      if (pop[s]) rd_d[s] = ptr_inc(rd_q[s]);
      case ({push[s], pop[s]})
        2'b10:   fcnt_d[s] = fcnt_q[s] + FW'(1);
        2'b01:   fcnt_d[s] = fcnt_q[s] - FW'(1);
        default: fcnt_d[s] = fcnt_q[s];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend_q <= '0;
      for (int m = 0; m < NB_MST; m++) begin
        cnt_q[m] <= '0;
        tgt_q[m] <= '0;
      end
      for (int s = 0; s < NB_SLV; s++) begin
        rr_q[s]   <= '0;
        wr_q[s]   <= '0;
        rd_q[s]   <= '0;
        fcnt_q[s] <= '0;
        for (int i = 0; i < OUTSTANDING; i++) mem_q[s][i] <= '0;
      end
    end else begin
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
      mem_q      <= mem_d;
    end
  end

  for (genvar s = 0; s < NB_SLV; s++) begin : g_rvalid_chk
    a_no_rvalid_on_empty: assert property (@(posedge clk) disable iff (rst)
      !(slv_rvalid_i[s] && (fcnt_q[s] == '0)));
  end

endmodule

// File: tb/tb_mem_xbar_rr.sv
// Bench for mem_xbar_rr: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with responsive slaves.
module tb_mem_xbar_rr;

  localparam int NM  = 3;
  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int OUT = 2;
  localparam logic [31:0] ERR_RD = 32'hBADACCE5;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    mst_req, mst_we;
  logic [NM*AW-1:0] mst_addr;
  logic [NM*BW-1:0] mst_be;
  logic [NM*DW-1:0] mst_wdata;
  logic [NM-1:0]    mst_gnt_o, mst_rvalid_o, mst_err_o;
  logic [NM*DW-1:0] mst_rdata_o;
  logic [NS-1:0]    slv_req_o, slv_we_o;
  logic [NS*AW-1:0] slv_addr_o;
  logic [NS*BW-1:0] slv_be_o;
  logic [NS*DW-1:0] slv_wdata_o;
  logic [NS-1:0]    slv_gnt, slv_rvalid, slv_err;
  logic [NS*DW-1:0] slv_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: per-slave queue of masters awaiting a response.
  int fifo_q [NS][$];
  int rr_m   [NS];
  int cnt_m  [NM];
  int tgt_m  [NM];
  bit errp_m [NM];
  logic [NM-1:0] mdl_gnt;

  logic [31:0] edge_a [4] = '{32'h000F_FFFF, 32'h0010_0000, 32'h001F_FFFF, 32'h0020_0000};
  int          edge_t [4] = '{0, 1, 1, 3};
  logic [2:0]  cont_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int          cont_m [4] = '{0, 1, 2, 0};

  mem_xbar_rr dut (
    .clk(clk), .rst(rst),
    .mst_req_i(mst_req), .mst_addr_i(mst_addr), .mst_we_i(mst_we), .mst_be_i(mst_be),
    .mst_wdata_i(mst_wdata), .mst_gnt_o(mst_gnt_o), .mst_rvalid_o(mst_rvalid_o),
    .mst_rdata_o(mst_rdata_o), .mst_err_o(mst_err_o),
    .slv_req_o(slv_req_o), .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_be_o(slv_be_o),
    .slv_wdata_o(slv_wdata_o), .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .slv_err_i(slv_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    if (a <= 32'h000F_FFFF) return 0;
    if (a >= 32'h0010_0000 && a <= 32'h001F_FFFF) return 1;
    if (a >= 32'h1A10_0000 && a <= 32'h1A11_FFFF) return 2;
    return NS;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0:  return 32'h0000_0000;
      1:  return 32'h0000_0010;
      2:  return 32'h000F_FFFF;
      3:  return 32'h0010_0000;
      4:  return 32'h001F_FFFF;
      5:  return 32'h0012_3454;
      6:  return 32'h1A10_0000;
      7:  return 32'h1A11_FFFF;
      8:  return 32'h0020_0000;
      9:  return 32'h8000_0000;
      10: return 32'hFFFF_FFFF;
      default: return 32'h1A0F_FFFC;
    endcase
  endfunction

  // Model/compare process: expected outputs from the current model state and inputs, then commit.
  always @(negedge clk) begin : model_cmp
    logic [NM-1:0]    e_gnt, e_rv, e_err;
    logic [NM*DW-1:0] e_rd;
    logic [NS-1:0]    e_sreq, e_pop;
    int dec [NM];
    bit ok  [NM];
    int win [NS];
    int c, m;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        fifo_q[s].delete();
        rr_m[s] = 0;
      end
      for (int i = 0; i < NM; i++) begin
        cnt_m[i] = 0; tgt_m[i] = 0; errp_m[i] = 0;
      end
      mdl_gnt = '0;
      chk("rst_gnt", mst_gnt_o, '0);
      chk("rst_rvalid", mst_rvalid_o, '0);
      chk("rst_slv_req", slv_req_o, '0);
      chk("rst_rdata", mst_rdata_o, '0);
    end else begin
      e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_sreq = '0; e_pop = '0;
      for (int i = 0; i < NM; i++) begin
        dec[i] = ref_decode(mst_addr[i*AW +: AW]);
        ok[i]  = mst_req[i] && (cnt_m[i] == 0 || tgt_m[i] == dec[i]);
      end
      for (int s = 0; s < NS; s++) begin
        win[s] = -1;
        for (int k = 0; k < NM; k++) begin
          c = (rr_m[s] + k) % NM;
          if (win[s] < 0 && ok[c] && dec[c] == s) win[s] = c;
        end
        if (win[s] >= 0 && fifo_q[s].size() < OUT) begin
          e_sreq[s] = 1'b1;
          if (slv_gnt[s]) e_gnt[win[s]] = 1'b1;
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (ok[i] && dec[i] == NS) e_gnt[i] = 1'b1;
        if (errp_m[i]) begin
          e_rv[i] = 1'b1; e_err[i] = 1'b1; e_rd[i*DW +: DW] = ERR_RD;
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (slv_rvalid[s] && fifo_q[s].size() > 0) begin
          e_pop[s] = 1'b1;
          m = fifo_q[s][0];
          e_rv[m] = 1'b1;
          e_err[m] = slv_err[s];
          e_rd[m*DW +: DW] = slv_rdata[s*DW +: DW];
        end
      end
      chk("gnt", mst_gnt_o, e_gnt);
      chk("rvalid", mst_rvalid_o, e_rv);
      chk("err", mst_err_o & mst_rvalid_o, e_err);
      chk("rdata", mst_rdata_o, e_rd);
      chk("slv_req", slv_req_o, e_sreq);
      for (int s = 0; s < NS; s++) begin
        if (e_sreq[s]) begin
          chk("slv_addr", slv_addr_o[s*AW +: AW], mst_addr[win[s]*AW +: AW]);
          chk("slv_we", slv_we_o[s], mst_we[win[s]]);
          chk("slv_be", slv_be_o[s*BW +: BW], mst_be[win[s]*BW +: BW]);
          chk("slv_wdata", slv_wdata_o[s*DW +: DW], mst_wdata[win[s]*DW +: DW]);
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (e_pop[s]) void'(fifo_q[s].pop_front());
        if (e_sreq[s] && slv_gnt[s]) begin
          fifo_q[s].push_back(win[s]);
          rr_m[s] = (win[s] + 1) % NM;
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (e_gnt[i]) begin
          tgt_m[i] = dec[i];
          cnt_m[i]++;
        end
        if (e_rv[i]) cnt_m[i]--;
        errp_m[i] = ok[i] && dec[i] == NS;
      end
      mdl_gnt = e_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mst(input int m, input logic req, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    mst_req[m]          = req;
    mst_addr[m*AW +: AW] = a;
    mst_we[m]           = we;
    mst_be[m*BW +: BW]   = be;
    mst_wdata[m*DW +: DW] = wd;
  endtask

  task automatic rand_slaves(input bit allow_rsp);
    for (int s = 0; s < NS; s++) begin
      slv_gnt[s]           = ($urandom_range(0, 3) != 0);
      slv_rvalid[s]        = allow_rsp && fifo_q[s].size() > 0 && ($urandom_range(0, 2) != 0);
      slv_rdata[s*DW +: DW] = $urandom();
      slv_err[s]           = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin : main
    logic [2:0] e_req;
    bit done;
    int busy;
    rst = 1'b1;
    mst_req = '0; mst_we = '0; mst_addr = '0; mst_be = '0; mst_wdata = '0;
    slv_gnt = '0; slv_rvalid = '0; slv_rdata = '0; slv_err = '0;
    #1;
    chk("reset_gnt", mst_gnt_o, '0);
    chk("reset_slv_req", slv_req_o, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention: all masters hammer slave 0, which answers one cycle after each grant.
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) for (int m = 0; m < NM; m++) set_mst(m, 1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
      if (i == 4) mst_req = '0;
      slv_gnt    = 3'b111;
      slv_rvalid = '0;
      slv_rvalid[0] = fifo_q[0].size() > 0;
      slv_rdata[31:0] = 32'hD000_0000 + i;
      peek();
      if (i < 4) chk("cont_gnt", mst_gnt_o, cont_g[i]);
      if (i > 0) begin
        chk("cont_rvalid", mst_rvalid_o, cont_g[i-1]);
        chk("cont_rdata", mst_rdata_o[cont_m[i-1]*DW +: DW], 32'hD000_0000 + i);
      end
    end
    tick();
    slv_rvalid = '0;

    // Unmapped address: error slave grants at once and answers the next cycle.
    tick();
    set_mst(1, 1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    peek();
    chk("unmap_gnt", mst_gnt_o, 3'b010);
    chk("unmap_slv_req", slv_req_o, 3'b000);
    tick();
    mst_req = '0;
    peek();
    chk("unmap_rvalid", mst_rvalid_o, 3'b010);
    chk("unmap_err", mst_err_o, 3'b010);
    chk("unmap_rdata", mst_rdata_o[63:32], 32'hBADACCE5);
    chk("unmap_slv_req2", slv_req_o, 3'b000);

    // Target lock: M0 may not switch to slave 2 until slave 1 has answered.
    tick();
    slv_gnt = 3'b111;
    set_mst(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    peek();
    chk("lock_gnt0", mst_gnt_o, 3'b001);
    for (int i = 1; i <= 5; i++) begin
      tick();
      mst_addr[31:0]   = 32'h1A10_0000;
      slv_rvalid[1]    = (i == 5);
      slv_rdata[63:32] = 32'h1111_1111;
      peek();
      chk("lock_blocked", mst_gnt_o[0], 1'b0);
      if (i == 5) chk("lock_rsp1", mst_rvalid_o[0], 1'b1);
    end
    tick();
    slv_rvalid = '0;
    peek();
    chk("lock_gnt2", mst_gnt_o[0], 1'b1);
    tick();
    mst_req = '0;
    slv_rvalid[2]    = 1'b1;
    slv_rdata[95:64] = 32'h2222_2222;
    peek();
    chk("lock_rsp2", mst_rvalid_o[0], 1'b1);
    chk("lock_rdata2", mst_rdata_o[31:0], 32'h2222_2222);
    tick();
    slv_rvalid = '0;

    // FIFO full: two grants outstanding on slave 0 mask its request.
    tick();
    slv_gnt = 3'b001;
    for (int m = 0; m < NM; m++) set_mst(m, 1'b1, 32'h0000_0020, 1'b1, 4'h3, 32'hCAFE_0000 + m);
    peek();
    chk("full_req1", slv_req_o[0], 1'b1);
    tick();
    peek();
    chk("full_req2", slv_req_o[0], 1'b1);
    tick();
    peek();
    chk("full_masked", slv_req_o[0], 1'b0);
    chk("full_no_gnt", mst_gnt_o, 3'b000);
    tick();
    slv_rvalid[0] = 1'b1;
    peek();
    chk("full_masked_pop", slv_req_o[0], 1'b0);
    tick();
    slv_rvalid[0] = 1'b0;
    peek();
    chk("full_reassert", slv_req_o[0], 1'b1);

    // Reset with two transactions in flight; a late slave response is dropped.
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", mst_gnt_o, '0);
    chk("arst_rvalid", mst_rvalid_o, '0);
    chk("arst_err", mst_err_o, '0);
    chk("arst_rdata", mst_rdata_o, '0);
    chk("arst_slv_req", slv_req_o, '0);
    chk("arst_slv_addr", slv_addr_o, '0);
    chk("arst_slv_we", slv_we_o, '0);
    chk("arst_slv_be", slv_be_o, '0);
    chk("arst_slv_wdata", slv_wdata_o, '0);
    tick();
    slv_rvalid[0] = 1'b1;
    peek();
    chk("late_rvalid", mst_rvalid_o, '0);
    tick();
    rst = 1'b0;
    slv_rvalid = '0;
    mst_req = '0;
    peek();
    chk("post_rst_rvalid", mst_rvalid_o, '0);
    chk("post_rst_slv_req", slv_req_o, '0);

    // Range edges are inclusive.
    for (int i = 0; i < 4; i++) begin
      chk("dec_edge", ref_decode(edge_a[i]), edge_t[i]);
      tick();
      slv_gnt = '0;
      set_mst(2, 1'b1, edge_a[i], 1'b0, 4'hF, 32'h0);
      e_req = (edge_t[i] < NS) ? 3'(1 << edge_t[i]) : 3'b000;
      peek();
      chk("edge_slv_req", slv_req_o, e_req);
      chk("edge_err_gnt", mst_gnt_o[2], edge_t[i] == NS);
      tick();
      mst_req = '0;
      peek();
    end

    // Randomized traffic; masters hold a request until it is granted.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      tick();
      for (int m = 0; m < NM; m++) begin
        if (!mst_req[m] || mdl_gnt[m]) begin
          if ($urandom_range(0, 99) < 60)
            set_mst(m, 1'b1, pick_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
          else
            mst_req[m] = 1'b0;
        end
      end
      rand_slaves(1'b1);
    end

    // Drain everything still outstanding.
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      mst_req = '0;
      rand_slaves(1'b1);
      busy = 0;
      for (int s = 0; s < NS; s++) busy += fifo_q[s].size();
      for (int m = 0; m < NM; m++) busy += cnt_m[m];
      done = (busy == 0);
    end
    chk("drain_done", done, 1'b1);
    tick();
    slv_rvalid = '0;
    peek();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
